// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_set_ctrl
// Brief   : Run/set sequencer for a digital clock: button edge detect, field
//           select, increment strobes, display page, blink and idle timeout.
// Rev     : 1.0  initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic [5:0] inc,
    output logic [2:0] field_sel,
    output logic       page,
    output logic       blink
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_SET_S   = 3'd1,
        S_SET_MIN = 3'd2,
        S_SET_H   = 3'd3,
        S_SET_D   = 3'd4,
        S_SET_MON = 3'd5,
        S_SET_Y   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_adv;
    logic          r_mode_prev;
    logic          r_inc_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_run_en;
    logic [5:0]    r_inc;
    logic [5:0]    w_inc_nxt;
    logic          r_page;
    logic          w_page_nxt;
    logic          r_blink;
    logic          w_blink_nxt;
    logic          w_mode_p;
    logic          w_inc_p;
    logic [2:0]    w_fidx;

    assign w_mode_p = btn_mode & ~r_mode_prev;
    assign w_inc_p  = btn_inc & ~r_inc_prev;
    assign w_fidx   = 3'(r_state) - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sample the live level so a button held through reset is not a press
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_run_en    <= 1'b1;
            r_inc       <= '0;
            r_page      <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_run_en    <= (w_state_nxt == S_RUN);
            r_inc       <= w_inc_nxt;
            r_page      <= w_page_nxt;
            r_blink     <= w_blink_nxt;
        end
    end

    always_comb begin
        w_adv = S_RUN;
        case (r_state)
            S_RUN:     w_adv = S_SET_S;
            S_SET_S:   w_adv = S_SET_MIN;
            S_SET_MIN: w_adv = S_SET_H;
            S_SET_H:   w_adv = S_SET_D;
            S_SET_D:   w_adv = S_SET_MON;
            S_SET_MON: w_adv = S_SET_Y;
            default:   w_adv = S_RUN;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_blink_nxt = r_blink;
        w_page_nxt  = r_page;
        w_inc_nxt   = '0;

        // Priority: mode press, then inc press, then tick/timeout
        if (w_mode_p) begin
            w_state_nxt = w_adv;
            w_cnt_nxt   = '0;
            w_blink_nxt = 1'b0;
        end else if (r_state == S_RUN) begin
            w_cnt_nxt   = '0;
            w_blink_nxt = 1'b0;
            if (w_inc_p)
                w_page_nxt = ~r_page;
        end else if (r_state > S_SET_Y) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_blink_nxt = 1'b0;
        end else if (w_inc_p) begin
            w_inc_nxt   = 6'd1 << w_fidx;
            w_cnt_nxt   = '0;
            w_blink_nxt = 1'b0;
        end else if (tick) begin
            if (r_cnt == C_LAST) begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
                w_blink_nxt = 1'b0;
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
                w_blink_nxt = ~r_blink;
            end
        end

        // Set states pin the page to the one showing the field being adjusted
        case (w_state_nxt)
            S_RUN:                       if (r_state != S_RUN) w_page_nxt = 1'b0;
            S_SET_S, S_SET_MIN, S_SET_H: w_page_nxt = 1'b0;
            default:                     w_page_nxt = 1'b1;
        endcase
    end

    assign run_en    = r_run_en;
    assign inc       = r_inc;
    assign field_sel = 3'(r_state);
    assign page      = r_page;
    assign blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_set_ctrl
// Brief   : Directed scoreboard bench for clock_set_ctrl with TIMEOUT = 3.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b0;
    logic       run_en;
    logic [5:0] inc;
    logic [2:0] field_sel;
    logic       page;
    logic       blink;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    logic       e_run;
    logic [5:0] e_inc;
    logic [2:0] e_fs;
    logic       e_page;
    logic       e_blink;

    clock_set_ctrl #(.TIMEOUT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .run_en    (run_en),
        .inc       (inc),
        .field_sel (field_sel),
        .page      (page),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input logic r, input logic [5:0] i, input logic [2:0] f,
                            input logic p, input logic b);
        e_run = r; e_inc = i; e_fs = f; e_page = p; e_blink = b;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, check after the edge
    task automatic cyc(input logic m, input logic ib, input logic t, input string tag);
        logic [11:0] obs;
        logic [11:0] exp_v;
        string       tg;
        btn_mode = m; btn_inc = ib; tick = t;
        exp_q.push_back({e_run, e_inc, e_fs, e_page, e_blink});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs   = {run_en, inc, field_sel, page, blink};
        exp_v = exp_q.pop_front();
        tg    = tag_q.pop_front();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed run/inc/fs/pg/bl=%b_%b_%0d_%b_%b expected=%b_%b_%0d_%b_%b",
                   tg, obs[11], obs[10:5], obs[4:2], obs[1], obs[0],
                   exp_v[11], exp_v[10:5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
        @(negedge clk);
    endtask

    // Mode press (one high cycle, one low cycle) landing on field f
    task automatic press_mode(input logic [2:0] f, input string tag);
        expect_v(f == 3'd0, 6'd0, f, f >= 3'd4, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, tag);
        cyc(1'b0, 1'b0, 1'b0, {tag, "_rel"});
    endtask

    initial begin
        @(negedge clk);
        // Reset with mode held, then release and press cleanly
        expect_v(1'b1, 6'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, "reset0");
        cyc(1'b1, 1'b0, 1'b0, "reset1");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, "held_thru_reset");
        cyc(1'b0, 1'b0, 1'b0, "released");
        cyc(1'b0, 1'b0, 1'b1, "tick_in_run");
        press_mode(3'd1, "first_press");

        for (int k = 2; k <= 7; k++) press_mode(3'(k % 7), "walk_to_run");
        for (int k = 1; k <= 7; k++) press_mode(3'(k % 7), "walk7");

        // SET_H: three increments each held 4 cycles
        for (int k = 1; k <= 3; k++) press_mode(3'(k), "to_set_h");
        for (int n = 0; n < 3; n++) begin
            expect_v(1'b0, 6'b000100, 3'd3, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, "inc_h_pulse");
            expect_v(1'b0, 6'b000000, 3'd3, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, "inc_h_held1");
            cyc(1'b0, 1'b1, 1'b0, "inc_h_held2");
            cyc(1'b0, 1'b1, 1'b0, "inc_h_held3");
            cyc(1'b0, 1'b0, 1'b0, "inc_h_low");
        end
        for (int k = 4; k <= 7; k++) press_mode(3'(k % 7), "back_to_run");

        // RUN: inc toggles page; then simultaneous mode+inc
        expect_v(1'b1, 6'd0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, "page_to_1");
        cyc(1'b0, 1'b0, 1'b0, "page_hold_1");
        expect_v(1'b1, 6'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, "page_to_0");
        cyc(1'b0, 1'b0, 1'b0, "page_hold_0");
        expect_v(1'b0, 6'd0, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, "mode_beats_inc");
        cyc(1'b0, 1'b0, 1'b0, "mode_beats_inc_rel");

        // SET_MON timeout sequence with a press on the third tick
        for (int k = 2; k <= 5; k++) press_mode(3'(k), "to_set_mon");
        expect_v(1'b0, 6'd0, 3'd5, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, "tick1_blink1");
        cyc(1'b0, 1'b0, 1'b0, "gap1");
        expect_v(1'b0, 6'd0, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "tick2_blink0");
        cyc(1'b0, 1'b0, 1'b0, "gap2");
        expect_v(1'b0, 6'b010000, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, "tick3_press_no_timeout");
        expect_v(1'b0, 6'd0, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, "gap3");
        expect_v(1'b0, 6'd0, 3'd5, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, "tick4");
        expect_v(1'b0, 6'd0, 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "tick5");
        cyc(1'b0, 1'b0, 1'b0, "gap5");
        expect_v(1'b1, 6'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "tick6_timeout");
        cyc(1'b0, 1'b0, 1'b0, "after_timeout");

        // Reset while an inc pulse is high in SET_Y
        for (int k = 1; k <= 6; k++) press_mode(3'(k), "to_set_y");
        expect_v(1'b0, 6'b100000, 3'd6, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, "inc_y_pulse");
        rst = 1'b1;
        expect_v(1'b1, 6'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, "reset_mid_pulse");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode/set sequencer for the `top_clock1` digital clock. It turns two raw push-button levels into a run/set state machine, one-cycle increment strobes for the six time/date counters (s, min, h, d, mon, y), a display-page select and a field-blink enable. It sits between the board buttons and the counter/segment datapath. The counters only advance on `tick` while `run_en` is high, and are adjusted only through `inc`.

## Interface
- TIMEOUT, 30: number of `tick` strobes with no button press in any set state before automatic return to RUN; legal range ≥1.

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- tick  in  1  1 Hz strobe, high for exactly one `clk` cycle
- btn_mode  in  1  mode button level, already synchronized to `clk`
- btn_inc  in  1  increment button level, already synchronized to `clk`
- run_en  out  1  1 = counters free-run on `tick`; 0 = frozen for setting
- inc  out  6  one-hot increment strobe: bit0 s, bit1 min, bit2 h, bit3 d, bit4 mon, bit5 y
- field_sel  out  3  0 = none (RUN), 1..6 = field being set (s..y)
- page  out  1  display page: 0 = time h:m:s, 1 = date d/mon/y
- blink  out  1  1 = datapath blanks the digits of the `field_sel` field

## Operation
- Edge detect: a press is `btn & ~btn_prev`, where `btn_prev` is a register per button. During `rst`, `btn_prev` loads the current level, so a button held through reset is not a press.
- States and encoding (this encoding equals `field_sel`): RUN = 0, SET_S = 1, SET_MIN = 2, SET_H = 3, SET_D = 4, SET_MON = 5, SET_Y = 6. Values 7+ are unreachable and go to RUN.
- Mode press advances the state: RUN → SET_S → SET_MIN → SET_H → SET_D → SET_MON → SET_Y → RUN.
- Inc press:
  - In RUN: toggles `page`; `inc` stays 0.
  - In SET_x: `inc[x-1]` pulses for one cycle. Field range and wrap belong to the counters, not this block.
- Mode press and inc press in the same cycle: mode wins; the inc press is discarded, with no pulse and no page toggle.
- `run_en` = 1 only in RUN.
- `page` in set states is forced to 0 for SET_S/SET_MIN/SET_H and to 1 for SET_D/SET_MON/SET_Y. On entry to RUN, `page` = 0.
- `blink`:
  - 0 in RUN.
  - In set states, toggles on each `tick`.
  - Cleared to 0 on entry to any set state and on every inc press, so the field stays visible while it is being adjusted.
- Idle counter, width clog2(TIMEOUT+1):
  - Cleared on entry to any set state and on any press.
  - Increments on `tick` in set states.
  - When a `tick` arrives with the counter at TIMEOUT-1, the state goes to RUN and the counter clears.
  - A press and a `tick` in the same cycle: the press wins, the counter clears, `blink` clears, and there is no timeout.
- Mode press and timeout in the same cycle: the mode advance wins.

## Timing
- Every output is a register. Reset values: `run_en` = 1, `inc` = 0, `field_sel` = 0, `page` = 0, `blink` = 0. Idle counter = 0, state = RUN.
- Latency: a button level first sampled high at edge k makes the resulting state, `inc` pulse, `page` or `blink` change visible after edge k. `inc` returns to 0 after edge k+1.
- Holding a button produces exactly one press; there is no auto-repeat. A new press requires at least one low sample.
- `rst` asserted in any state, including mid-pulse: the next edge forces all reset values. Any `inc` pulse is cut after that edge.
- Timeout: after the TIMEOUT-th press-free `tick`, `run_en` = 1 and `field_sel` = 0 one edge later.

## Test plan
- Reset with `btn_mode` held high, then release and press `btn_mode` once → no state change while held through reset; after the clean press `field_sel` = 1, `run_en` = 0, `page` = 0, `blink` = 0.
- From RUN press `btn_mode` 7 times → `field_sel` walks 1, 2, 3, 4, 5, 6, 0; `page` walks 0, 0, 0, 1, 1, 1, 0; `run_en` = 1 only at the end.
- In SET_H press `btn_inc` 3 times, each held 4 cycles → exactly 3 one-cycle pulses of `inc` = 6'b000100, each one edge after its press; `blink` = 0 after each pulse.
- In RUN press `btn_inc` twice → `page` goes 0 → 1 → 0 and `inc` stays 0. Then assert `btn_mode` and `btn_inc` rising in the same cycle → `field_sel` = 1, `inc` = 0, `page` = 0.
- TIMEOUT = 3, in SET_MON, give 2 ticks, then a `btn_inc` press coincident with the 3rd tick, then 3 more ticks → `inc` = 6'b010000 once, `blink` toggles 0→1→0 on ticks 1 and 2, no timeout at tick 3, return to RUN (`run_en` = 1, `field_sel` = 0) exactly one edge after tick 6.
- Assert `rst` on the cycle an `inc` pulse is high in SET_Y → after the next edge all outputs are at reset values and `inc` = 0.
